// File: rtl/uart_cmd_parser.sv
// Command-frame parser between the UART RX and TX FIFOs. It turns
// SYNC/CMD/ADDR/DATA/CHK frames into register-bus accesses and sends a 5-byte ACK or NACK.
module uart_cmd_parser #(
  parameter int                BITLEN         = 8,
  parameter logic [BITLEN-1:0] SYNC_BYTE      = BITLEN'(8'hA5),
  parameter int                TIMEOUT_CYCLES = 1_000_000,
  parameter int                ERR_CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [BITLEN-1:0]        rx_data,
  input  logic                     rx_empty,
  output logic                     rx_read,
  output logic [BITLEN-1:0]        tx_data,
  output logic                     tx_write,
  input  logic                     tx_full,
  output logic [BITLEN-1:0]        reg_addr,
  output logic [BITLEN-1:0]        reg_wdata,
  output logic                     reg_wr,
  output logic                     reg_rd,
  input  logic [BITLEN-1:0]        reg_rdata,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     busy
);

  localparam logic [BITLEN-1:0] CMD_WR   = BITLEN'(1);
  localparam logic [BITLEN-1:0] CMD_RD   = BITLEN'(2);
  localparam logic [BITLEN-1:0] ACK_FLAG = BITLEN'(1) << (BITLEN - 1);
  localparam logic [BITLEN-1:0] NACK_CHK = BITLEN'(1);
  localparam logic [BITLEN-1:0] NACK_CMD = BITLEN'(2);
  localparam logic [BITLEN-1:0] NACK_TO  = BITLEN'(3);
  localparam int                TO_W     = $clog2(TIMEOUT_CYCLES) + 2;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, EXEC, RD_WAIT, RESP
  } state_t;

  state_t            state;
  logic              fetch_wait;
  logic [TO_W-1:0]   to_cnt;
  logic [BITLEN-1:0] cmd_q, addr_q, data_q;
  logic [BITLEN-1:0] resp_b1, resp_b2, resp_b3;
  logic [2:0]        resp_idx;
  logic              resp_act;
  logic [BITLEN-1:0] resp_byte;
  logic              in_frame;
  logic              nack_go;
  logic [BITLEN-1:0] nack_code;

  assign in_frame = (state inside {S_CMD, S_ADDR, S_DATA, S_CHK});

  // NACK decision: bad checksum or command on the CHK byte, or an idle frame timing out
  always_comb begin
    nack_go   = 1'b0;
    nack_code = '0;
    if (state == S_CHK && fetch_wait) begin
      if (rx_data != (cmd_q ^ addr_q ^ data_q)) begin
        nack_go   = 1'b1;
        nack_code = NACK_CHK;
      end else if (cmd_q != CMD_WR && cmd_q != CMD_RD) begin
        nack_go   = 1'b1;
        nack_code = NACK_CMD;
      end
    end else if (in_frame && !fetch_wait && !rx_read && to_cnt >= TO_LAST) begin
      nack_go   = 1'b1;
      nack_code = NACK_TO;
    end
  end

  always_comb begin
    resp_byte = resp_b1 ^ resp_b2 ^ resp_b3;
    case (resp_idx)
      3'd0:    resp_byte = SYNC_BYTE;
      3'd1:    resp_byte = resp_b1;
      3'd2:    resp_byte = resp_b2;
      3'd3:    resp_byte = resp_b3;
      default: resp_byte = resp_b1 ^ resp_b2 ^ resp_b3;
    endcase
  end

  // The push strobe is gated combinationally so it can never coincide with tx_full
  assign tx_write = resp_act & ~tx_full;
  assign tx_data  = resp_act ? resp_byte : '0;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      rx_read    <= 1'b0;
      fetch_wait <= 1'b0;
      to_cnt     <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      resp_b1    <= '0;
      resp_b2    <= '0;
      resp_b3    <= '0;
      resp_idx   <= '0;
      resp_act   <= 1'b0;
      err_cnt    <= '0;
      busy       <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      case (state)
        IDLE, S_CMD, S_ADDR, S_DATA, S_CHK: begin
          // Fetch: rx_read for one cycle, then rx_data is captured a cycle later
          rx_read    <= 1'b0;
          fetch_wait <= rx_read;
          if (nack_go) begin
            state      <= RESP;
            resp_act   <= 1'b1;
            resp_idx   <= '0;
            resp_b1    <= '1;
            resp_b2    <= nack_code;
            resp_b3    <= '0;
            to_cnt     <= '0;
            fetch_wait <= 1'b0;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end else if (fetch_wait) begin
            to_cnt <= '0;
            case (state)
              IDLE: begin
                if (rx_data == SYNC_BYTE) begin
                  state <= S_CMD;
                  busy  <= 1'b1;
                end
              end
              S_CMD: begin
                cmd_q <= rx_data;
                state <= S_ADDR;
              end
              S_ADDR: begin
                addr_q <= rx_data;
                state  <= S_DATA;
              end
              S_DATA: begin
                data_q <= rx_data;
                state  <= S_CHK;
              end
              S_CHK: begin
                reg_addr <= addr_q;
                resp_b1  <= cmd_q | ACK_FLAG;
                resp_b2  <= addr_q;
                resp_b3  <= data_q;
                if (cmd_q == CMD_WR) begin
                  reg_wdata <= data_q;
                  reg_wr    <= 1'b1;
                end else begin
                  reg_rd <= 1'b1;
                end
                state <= EXEC;
              end
              default: ;
            endcase
          end else begin
            if (!rx_read && !rx_empty) rx_read <= 1'b1;
            if (in_frame) to_cnt <= to_cnt + 1'b1;
          end
        end
        EXEC: begin
          resp_idx <= '0;
          if (cmd_q == CMD_RD) begin
            state <= RD_WAIT;
          end else begin
            state    <= RESP;
            resp_act <= 1'b1;
          end
        end
        RD_WAIT: begin
          resp_b3  <= reg_rdata;
          state    <= RESP;
          resp_act <= 1'b1;
        end
        RESP: begin
          if (!tx_full) begin
            if (resp_idx == 3'd4) begin
              resp_idx <= '0;
              resp_act <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              resp_idx <= resp_idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
